// File: rtl/apb_cmd_master.sv
// Command-to-APB bridge: turns one cmd_* request into a single APB transfer and returns one rsp_*.
// Optional ACCESS watchdog built in when APB_MASTER_TIMEOUT_EN is defined.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for cmd_valid
// SETUP  | PSEL high, PENABLE low, command fields on the bus
// ACCESS | PSEL and PENABLE high, waiting for PREADY (or watchdog)
// RESP   | rsp_valid high, holding rdata/err until rsp_ready
module apb_cmd_master #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   timeout;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Counts stalled ACCESS cycles; the last allowed stall cycle triggers the abort.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if ((state == ACCESS) && !PREADY) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout = (state == ACCESS) && !PREADY &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rsp_err <= 1'b0;
        end else if (state == ACCESS) begin
            if (PREADY) begin
                rsp_err <= 1'b0;
            end else if (timeout) begin
                rsp_err <= 1'b1;
            end
        end
    end
`else
    // Without the watchdog ACCESS waits forever; TIMEOUT_CYC has no effect.
    assign timeout = 1'b0 & (TIMEOUT_CYC != 0);
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                PSEL      = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY || timeout) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bus fields are only loaded on accept, so they stay put for the whole transfer.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_rdata <= '0;
        end else begin
            if ((state == IDLE) && cmd_valid) begin
                PWRITE <= cmd_write;
                PADDR  <= cmd_addr;
                PWDATA <= cmd_wdata;
            end
            if (state == ACCESS) begin
                if (PREADY) begin
                    rsp_rdata <= PWRITE ? '0 : PRDATA;
                end else if (timeout) begin
                    rsp_rdata <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: inputs change and outputs are sampled on the falling edge of PCLK.
module tb_apb_cmd_master;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int TIMEOUT_CYC = 16;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    apb_cmd_master #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge PCLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (%0d/%0d checks passed so far)", passed, checks);
        $fatal(1, "time limit");
    end

    initial begin
        int          en_cnt;
        int          rise1;
        int          rise2;
        logic        prev_psel;
        logic [31:0] addr1;
        logic [31:0] addr2;
        logic [31:0] wd2;

        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        PRDATA    = 32'hdead_beef;
        PREADY    = 1'b0;

        // reset state
        step();
        step();
        chk("rst_psel", PSEL, 1'b0);
        chk("rst_penable", PENABLE, 1'b0);
        chk("rst_pwrite", PWRITE, 1'b0);
        chk("rst_paddr", PADDR, 32'h0);
        chk("rst_pwdata", PWDATA, 32'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        PRESET = 1'b0;
        step();

        // zero-wait write 0x04 / 0xaaaa_ffff
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h04;
        cmd_wdata = 32'haaaa_ffff;
        PREADY    = 1'b1;
        chk("wr_ready_n", cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0;
        chk("wr_psel_n1", PSEL, 1'b1);
        chk("wr_penable_n1", PENABLE, 1'b0);
        chk("wr_paddr_n1", PADDR, 32'h04);
        chk("wr_pwrite_n1", PWRITE, 1'b1);
        chk("wr_pwdata_n1", PWDATA, 32'haaaa_ffff);
        chk("wr_cmd_ready_n1", cmd_ready, 1'b0);
        step();
        chk("wr_psel_n2", PSEL, 1'b1);
        chk("wr_penable_n2", PENABLE, 1'b1);
        chk("wr_pwdata_n2", PWDATA, 32'haaaa_ffff);
        step();
        chk("wr_rsp_valid_n3", rsp_valid, 1'b1);
        chk("wr_rsp_err_n3", rsp_err, 1'b0);
        chk("wr_rsp_rdata_n3", rsp_rdata, 32'h0);
        chk("wr_psel_n3", PSEL, 1'b0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("wr_cmd_ready_n4", cmd_ready, 1'b1);
        chk("wr_rsp_valid_n4", rsp_valid, 1'b0);

        // read 0x00 with three wait states
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h00;
        PREADY    = 1'b0;
        step();
        cmd_valid = 1'b0;
        chk("rd_psel_n1", PSEL, 1'b1);
        chk("rd_pwrite_n1", PWRITE, 1'b0);
        en_cnt = 0;
        for (int i = 2; i <= 5; i++) begin
            step();
            if (i == 5) begin
                PREADY = 1'b1;
                PRDATA = 32'habfe_fabe;
            end
            en_cnt += int'(PENABLE);
        end
        step();
        PREADY = 1'b0;
        PRDATA = 32'hdead_beef;
        chk("rd_penable_cycles", en_cnt, 4);
        chk("rd_rsp_valid_n6", rsp_valid, 1'b1);
        chk("rd_rsp_rdata_n6", rsp_rdata, 32'habfe_fabe);
        chk("rd_rsp_err_n6", rsp_err, 1'b0);
        chk("rd_psel_n6", PSEL, 1'b0);

        // response held for five cycles while a second command is offered
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1;
            cmd_write = 1'b1;
            cmd_addr  = 32'h40;
            chk("hold_rsp_valid", rsp_valid, 1'b1);
            chk("hold_rsp_rdata", rsp_rdata, 32'habfe_fabe);
            chk("hold_cmd_ready", cmd_ready, 1'b0);
            step();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("hold_release_ready", cmd_ready, 1'b1);
        chk("hold_release_psel", PSEL, 1'b0);
        chk("hold_ignored_paddr", PADDR, 32'h00);

        // back-to-back writes 0x08 then 0x0C
        rsp_ready = 1'b1;
        PREADY    = 1'b1;
        rise1     = -1;
        rise2     = -1;
        prev_psel = 1'b0;
        addr1     = '0;
        addr2     = '0;
        wd2       = '0;
        for (int k = 0; k < 8; k++) begin
            if (PSEL && !prev_psel) begin
                if (rise1 < 0) begin
                    rise1 = k;
                    addr1 = PADDR;
                end else if (rise2 < 0) begin
                    rise2 = k;
                    addr2 = PADDR;
                    wd2   = PWDATA;
                end
            end
            prev_psel = PSEL;
            if (k == 0) begin
                cmd_valid = 1'b1;
                cmd_write = 1'b1;
                cmd_addr  = 32'h08;
                cmd_wdata = 32'h1111_1111;
            end
            if (k == 1) begin
                cmd_addr  = 32'h0C;
                cmd_wdata = 32'h2222_2222;
            end
            if (k == 5) cmd_valid = 1'b0;
            step();
        end
        chk("b2b_first_rise", rise1, 1);
        chk("b2b_second_rise", rise2, 5);
        chk("b2b_first_addr", addr1, 32'h08);
        chk("b2b_second_addr", addr2, 32'h0C);
        chk("b2b_second_wdata", wd2, 32'h2222_2222);

        // reset pulse in the middle of ACCESS
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h10;
        cmd_wdata = 32'h0000_0033;
        PREADY    = 1'b0;
        step();
        cmd_valid = 1'b0;
        step();
        chk("rstmid_penable_before", PENABLE, 1'b1);
        #1 PRESET = 1'b1;
        #1;
        chk("rstmid_psel", PSEL, 1'b0);
        chk("rstmid_penable", PENABLE, 1'b0);
        chk("rstmid_rsp_valid", rsp_valid, 1'b0);
        chk("rstmid_paddr", PADDR, 32'h0);
        chk("rstmid_cmd_ready", cmd_ready, 1'b1);
        step();
        PRESET = 1'b0;
        chk("rstmid_ready_after", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h14;
        PREADY    = 1'b1;
        PRDATA    = 32'h0000_1234;
        step();
        cmd_valid = 1'b0;
        chk("rstmid_first_psel", PSEL, 1'b1);
        chk("rstmid_first_paddr", PADDR, 32'h14);
        step();
        step();
        chk("rstmid_rsp_valid_after", rsp_valid, 1'b1);
        chk("rstmid_rsp_rdata_after", rsp_rdata, 32'h0000_1234);
        step();
        PRDATA    = 32'hdead_beef;
        rsp_ready = 1'b0;

        // PREADY stuck low
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h20;
        PREADY    = 1'b0;
        step();
        cmd_valid = 1'b0;
        en_cnt = 0;
`ifdef APB_MASTER_TIMEOUT_EN
        for (int i = 1; i <= 17; i++) begin
            en_cnt += int'(PENABLE);
            step();
        end
        chk("to_access_cycles", en_cnt, 16);
        chk("to_psel_dropped", PSEL, 1'b0);
        chk("to_rsp_valid", rsp_valid, 1'b1);
        chk("to_rsp_err", rsp_err, 1'b1);
        chk("to_rsp_rdata", rsp_rdata, 32'h0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("to_cmd_ready", cmd_ready, 1'b1);
`else
        for (int i = 1; i <= 20; i++) begin
            en_cnt += int'(PENABLE);
            step();
        end
        chk("stall_access_cycles", en_cnt, 19);
        chk("stall_penable", PENABLE, 1'b1);
        chk("stall_rsp_valid", rsp_valid, 1'b0);
        PREADY = 1'b1;
        PRDATA = 32'h5a5a_5a5a;
        step();
        PREADY = 1'b0;
        chk("stall_end_rsp_valid", rsp_valid, 1'b1);
        chk("stall_end_rsp_err", rsp_err, 1'b0);
        chk("stall_end_rsp_rdata", rsp_rdata, 32'h5a5a_5a5a);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("stall_cmd_ready", cmd_ready, 1'b1);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
